// File: rtl/mem_map_pkg.sv
// Purpose: shared memory-map constants and helpers for the CPU byte bus responder.
// Latency: n/a (constants and a combinational byte-select helper only).
// Backpressure: n/a.
package mem_map_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 32;

    // Region select lives in address bits [17:16]; 00/01 are both RAM.
    localparam logic [1:0] IO_REGION       = 2'b11;
    localparam logic [1:0] UNMAPPED_REGION = 2'b10;

    // I/O register offsets within the I/O region (address bits [2:0]).
    localparam logic [2:0] IO_UART = 3'h0;
    localparam logic [2:0] IO_CLK  = 3'h4;

    typedef logic [DATA_W-1:0] byte_t;

    // Pick byte idx (0 = least significant) out of a 32-bit word.
    function automatic byte_t word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [31:0] sh;
        sh = w >> {idx, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose: small synchronous byte FIFO with extra-MSB pointers.
// Latency: push visible at dout/empty the cycle after the push edge; dout is the live head.
// Backpressure: push ignored while full (even with a simultaneous pop), pop ignored while empty.
//
// Ports: clk/rst_n (async active-low), push/din write side, pop read side,
//        dout = current head byte, full/empty status.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra bit so full and empty are distinguishable
    // when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Purpose: CPU byte-bus responder: 128 KB RAM, UART TX/RX byte FIFOs, cycle counter, stop flag.
// Latency: reads return in mem_dout_out the cycle after the accepting edge; writes complete at it.
// Backpressure: cpu_rdy_out drops combinationally only for a TX-pushing write while TX FIFO is full.
//
// Ports: clk_in/rst_n_in (async active-low); mem_a_in/mem_wr_in/mem_din_in bus cycle from CPU;
//        mem_dout_out registered read data; cpu_rdy_out CPU stall; tx_* UART transmit stream
//        (valid/ready); rx_* UART receive stream (valid/ready); prog_stop_out sticky stop flag.
import mem_map_pkg::*;

module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [ADDR_W-1:0] mem_a_in,
    input  logic              mem_wr_in,
    input  logic [7:0]        mem_din_in,
    output logic [7:0]        mem_dout_out,
    output logic              cpu_rdy_out,
    output logic [7:0]        tx_data_out,
    output logic              tx_valid_out,
    input  logic              tx_ready_in,
    input  logic [7:0]        rx_data_in,
    input  logic              rx_valid_in,
    output logic              rx_ready_out,
    output logic              prog_stop_out
);

    // Address bits above the decoded window are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_a_in[ADDR_W-1:18];

    logic [1:0]        region;
    logic [2:0]        io_off;
    logic [RAM_AW-1:0] ram_addr;
    logic              is_ram;
    logic              is_io;
    logic              uart_sel;
    logic              clk_sel;
    logic              tx_wr_req;
    logic              acc_rd;
    logic              acc_wr;

    assign region   = mem_a_in[17:16];
    assign io_off   = mem_a_in[2:0];
    assign ram_addr = mem_a_in[RAM_AW-1:0];
    assign is_io    = (region == IO_REGION);
    assign is_ram   = (region != IO_REGION) && (region != UNMAPPED_REGION);
    assign uart_sel = is_io && (io_off == IO_UART);
    assign clk_sel  = is_io && (io_off == IO_CLK);

    // Writes that would push into TX: nonzero UART byte, or the stop register
    // (which pushes a 0x00 terminator).
    assign tx_wr_req = mem_wr_in && ((uart_sel && (mem_din_in != 8'h00)) || clk_sel);

    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_empty;
    logic [7:0] rx_dout;

    // Every cycle is a transaction; the only way to not accept is this stall.
    assign cpu_rdy_out = !(tx_wr_req && tx_full);
    assign acc_rd      = cpu_rdy_out && !mem_wr_in;
    assign acc_wr      = cpu_rdy_out && mem_wr_in;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (cpu_rdy_out && tx_wr_req),
        .din   (clk_sel ? 8'h00 : mem_din_in),
        .pop   (tx_ready_in),
        .dout  (tx_data_out),
        .full  (tx_full),
        .empty (tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push  (rx_valid_in),
        .din   (rx_data_in),
        .pop   (acc_rd && uart_sel),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_valid_out = !tx_empty;
    assign rx_ready_out = !rx_full;

    // RAM: plain synchronous array, contents survive reset.
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] ram_q;

    always_ff @(posedge clk_in) begin
        if (cpu_rdy_out && is_ram) begin
            if (mem_wr_in) ram[ram_addr] <= mem_din_in;
            else           ram_q         <= ram[ram_addr];
        end
    end

    logic [31:0] cycle_cnt;
    logic [31:0] cnt_snap;
    logic [7:0]  io_q;
    logic [7:0]  io_rd_nxt;
    logic        rd_from_ram;

    always_comb begin
        io_rd_nxt = 8'h00;
        if (is_io) begin
            case (io_off)
                IO_UART:             io_rd_nxt = rx_empty ? 8'h00 : rx_dout;
                IO_CLK:              io_rd_nxt = cycle_cnt[7:0];
                3'h5, 3'h6, 3'h7:    io_rd_nxt = word_byte(cnt_snap, io_off[1:0]);
                default:             io_rd_nxt = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cycle_cnt     <= '0;
            cnt_snap      <= '0;
            io_q          <= 8'h00;
            rd_from_ram   <= 1'b0;
            prog_stop_out <= 1'b0;
        end else begin
            if (!prog_stop_out) cycle_cnt <= cycle_cnt + 32'd1;
            if (acc_wr && clk_sel) prog_stop_out <= 1'b1;
            if (acc_rd) begin
                rd_from_ram <= is_ram;
                if (!is_ram) io_q <= io_rd_nxt;
            end
            // Reading the low counter byte freezes a copy so bytes 1..3 are coherent.
            if (acc_rd && clk_sel) cnt_snap <= cycle_cnt;
        end
    end

    // ram_q has no reset, so the select flag keeps the output at 0x00 after reset.
    assign mem_dout_out = rd_from_ram ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Purpose: self-checking bench for mem_io_responder (vector table + hand sequences).
// Latency: checks read data one cycle after the accepting edge.
// Backpressure: exercises TX-full stall, RX-full blocking and reset during a stall.
module tb_mem_io_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        cpu_rdy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        prog_stop;

    mem_io_responder dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .mem_a_in      (mem_a),
        .mem_wr_in     (mem_wr),
        .mem_din_in    (mem_din),
        .mem_dout_out  (mem_dout),
        .cpu_rdy_out   (cpu_rdy),
        .tx_data_out   (tx_data),
        .tx_valid_out  (tx_valid),
        .tx_ready_in   (tx_ready),
        .rx_data_in    (rx_data),
        .rx_valid_in   (rx_valid),
        .rx_ready_out  (rx_ready),
        .prog_stop_out (prog_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference cycle counter: counts edges from reset, freezes after an accepted stop write.
    logic [31:0] mcnt;
    logic        mstop;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt  <= 32'd0;
            mstop <= 1'b0;
        end else begin
            if (!mstop) mcnt <= mcnt + 32'd1;
            if (mem_wr && mem_a == 32'h30004 && cpu_rdy) mstop <= 1'b1;
        end
    end

    // Read-data scoreboard and TX stream queues.
    logic [7:0] sb_exp[$];
    string      sb_name[$];
    logic [7:0] tx_exp[$];
    logic [7:0] tx_got[$];

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) tx_got.push_back(tx_data);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        mem_wr  = 1'b0;
        mem_a   = 32'h20000;
        mem_din = 8'h00;
    endtask

    // One bus cycle. Called at posedge+1, returns at posedge+1 with idle inputs.
    task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d,
                        input logic chk, input logic [7:0] exp, input string nm);
        int n;
        logic [7:0] e;
        string en;
        n = 0;
        mem_wr = wr; mem_a = a; mem_din = d;
        #1;
        while (!cpu_rdy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cpu_rdy) check({nm, " rdy timeout"}, cpu_rdy, 1);
        if (chk) begin
            sb_exp.push_back(exp);
            sb_name.push_back(nm);
        end
        @(posedge clk); #1;
        if (chk && sb_exp.size() > 0) begin
            e  = sb_exp.pop_front();
            en = sb_name.pop_front();
            check(en, mem_dout, e);
        end
        set_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string nm);
        step(1'b0, a, 8'h00, 1'b1, exp, nm);
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 32'h20000, 8'h00, 1'b0, 8'h00, "idle");
    endtask

    task automatic tx_drain(input string nm);
        int n;
        n = 0;
        while (tx_got.size() < tx_exp.size() && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
        check({nm, " count"}, tx_got.size(), tx_exp.size());
        while (tx_got.size() > 0 && tx_exp.size() > 0)
            check(nm, tx_got.pop_front(), tx_exp.pop_front());
        check({nm, " empty"}, tx_valid, 0);
        tx_got.delete();
        tx_exp.delete();
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [14];
    logic [31:0] snap_m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h00010, 8'hA5, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 32'h00010, 8'h00, 1'b1, 8'hA5};
        tbl[2]  = '{1'b1, 32'h1FFFF, 8'h3C, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 32'h1FFFF, 8'h00, 1'b1, 8'h3C};
        tbl[4]  = '{1'b1, 32'h10010, 8'h5A, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 32'h00000, 8'h77, 1'b1, 8'h3C};   // write leaves read data held
        tbl[6]  = '{1'b0, 32'h10010, 8'h00, 1'b1, 8'h5A};
        tbl[7]  = '{1'b0, 32'h00000, 8'h00, 1'b1, 8'h77};
        tbl[8]  = '{1'b1, 32'h20010, 8'h99, 1'b0, 8'h00};   // unmapped write dropped
        tbl[9]  = '{1'b0, 32'h20010, 8'h00, 1'b1, 8'h00};
        tbl[10] = '{1'b0, 32'h00010, 8'h00, 1'b1, 8'hA5};   // not clobbered by unmapped write
        tbl[11] = '{1'b0, 32'h40010, 8'h00, 1'b1, 8'hA5};   // upper address bits ignored
        tbl[12] = '{1'b0, 32'h30001, 8'h00, 1'b1, 8'h00};
        tbl[13] = '{1'b1, 32'h30002, 8'hEE, 1'b1, 8'h00};   // other I/O offset dropped

        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        set_idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset dout", mem_dout, 8'h00);
        check("reset tx_valid", tx_valid, 0);
        check("reset rx_ready", rx_ready, 1);
        check("reset cpu_rdy", cpu_rdy, 1);
        check("reset prog_stop", prog_stop, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // RAM / decode vectors
        for (int i = 0; i < 14; i++)
            step(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));
        check("no tx from dropped writes", tx_valid, 0);

        // RX basic
        rx_valid = 1'b1; rx_data = 8'h41; idle_cycles(1);
        rx_data = 8'h42; idle_cycles(1);
        rx_valid = 1'b0;
        rd(32'h30000, 8'h41, "rx first");
        rd(32'h30000, 8'h42, "rx second");
        rd(32'h30000, 8'h00, "rx empty");

        // RX full: push blocked even with simultaneous pop
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h10 + 8'(i);
            idle_cycles(1);
        end
        check("rx full ready low", rx_ready, 0);
        rx_data = 8'h99;
        rd(32'h30000, 8'h10, "rx full pop");
        rx_valid = 1'b0;
        for (int i = 1; i < 8; i++) rd(32'h30000, 8'h10 + 8'(i), "rx drain");
        rd(32'h30000, 8'h00, "rx no write-through");

        // RX empty: pop with simultaneous push returns 0 but stores byte
        rx_valid = 1'b1; rx_data = 8'h55;
        rd(32'h30000, 8'h00, "rx empty pop+push");
        rx_valid = 1'b0;
        rd(32'h30000, 8'h55, "rx stored on empty");

        // TX fill and stall
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'h30000, 8'(i), 1'b0, 8'h00, "tx fill");
            tx_exp.push_back(8'(i));
        end
        mem_wr = 1'b1; mem_a = 32'h30000; mem_din = 8'h00;
        #1 check("zero write no stall", cpu_rdy, 1);
        @(posedge clk); #1;
        mem_din = 8'h09;
        #1 check("ninth write stalls", cpu_rdy, 0);
        repeat (2) @(posedge clk);
        #1 check("stall held", cpu_rdy, 0);
        tx_ready = 1'b1;
        #1 check("stall until pop", cpu_rdy, 0);
        @(posedge clk); #1;
        check("stall released", cpu_rdy, 1);
        @(posedge clk); #1;
        tx_exp.push_back(8'h09);
        set_idle();
        tx_drain("tx order");

        // Counter and snapshot
        snap_m = mcnt;
        rd(32'h30004, snap_m[7:0], "cnt byte0");
        idle_cycles(5);
        rd(32'h30005, snap_m[15:8], "snap byte1");
        rd(32'h30006, snap_m[23:16], "snap byte2");
        rd(32'h30007, snap_m[31:24], "snap byte3");

        // Program stop
        step(1'b1, 32'h30004, 8'h5A, 1'b0, 8'h00, "stop write");
        tx_exp.push_back(8'h00);
        check("prog_stop set", prog_stop, 1);
        tx_drain("stop tx");
        idle_cycles(7);
        rd(32'h30004, mcnt[7:0], "frozen cnt");
        check("prog_stop sticky", prog_stop, 1);

        // Reset during a stalled TX write
        rd(32'h00010, 8'hA5, "pre-reset read");
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx_valid = (i == 0);
            rx_data  = 8'h66;
            step(1'b1, 32'h30000, 8'h80 + 8'(i), 1'b0, 8'h00, "tx refill");
        end
        rx_valid = 1'b0;
        mem_wr = 1'b1; mem_a = 32'h30000; mem_din = 8'hC3;
        #1 check("pre-reset stall", cpu_rdy, 0);
        #3 rst_n = 1'b0;
        #1;
        check("rst cpu_rdy", cpu_rdy, 1);
        check("rst tx_valid", tx_valid, 0);
        check("rst dout", mem_dout, 8'h00);
        check("rst rx_ready", rx_ready, 1);
        check("rst prog_stop", prog_stop, 0);
        set_idle();
        tx_exp.delete();
        tx_got.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(32'h30000, 8'h00, "rx cleared by reset");
        for (int n = 0; n < 1000 && mcnt != 32'd300; n++) idle_cycles(1);
        rd(32'h30004, 8'h2C, "cnt at 300");
        rd(32'h30005, 8'h01, "cnt300 byte1");
        rd(32'h30006, 8'h00, "cnt300 byte2");
        check("stalled write lost", tx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
